// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared control types and constants for the I2S transmit path
`timescale 1ns/1ps
package ctrl_pkg;

  typedef enum logic [1:0] {
    MOFF = 2'd0,
    MT   = 2'd1,
    MR   = 2'd2
  } mode_t;

  typedef enum logic {
    f16bits = 1'b0,
    f32bits = 1'b1
  } frame_size_t;

  typedef struct packed {
    mode_t       mode;
    logic        stereo;
    frame_size_t frame_size;
  } OP_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_t;

  localparam int W16 = 16;
  localparam int W32 = 32;

  // Bit-counter reload value: index of the MSB for the selected slot width.
  function automatic logic [4:0] last_bit(input frame_size_t fs);
    return (fs == f32bits) ? 5'(W32 - 1) : 5'(W16 - 1);
  endfunction

endpackage

// File: rtl/sclk_edge_det.sv
// rtl/sclk_edge_det.sv - sclk synchronizer and one-pclk falling-edge event
`timescale 1ns/1ps
module sclk_edge_det
  import ctrl_pkg::*;
(
  input  logic i_pclk,
  input  logic i_rst,
  input  logic i_sclk,
  output logic o_fall
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync_d;

  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync1  <= i_sclk;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  assign o_fall = r_sync_d & ~r_sync2;

endmodule

// File: rtl/i2s_tx_serializer.sv
// rtl/i2s_tx_serializer.sv - I2S transmit serializer; I2S_TX_UNDERRUN_CNT_EN adds underrun_cnt
`timescale 1ns/1ps
module i2s_tx_serializer
  import ctrl_pkg::*;
(
  input  logic        pclk,
  input  logic        rst,
  input  logic        sclk,
  input  OP_t         OP,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        ws,
  output logic        sd,
  output logic        underrun,
  output logic        busy
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [7:0]  underrun_cnt
`endif
);

  tx_state_t   r_state;
  logic        r_ws;
  logic        r_sd;
  logic [4:0]  r_cnt;
  logic [31:0] r_shift;
  logic        r_w32;

  tx_state_t   w_state_nxt;
  logic        w_ws_nxt;
  logic        w_sd_nxt;
  logic [4:0]  w_cnt_nxt;
  logic [31:0] w_shift_nxt;
  logic        w_w32_nxt;
  logic        w_fall;
  logic        w_fetch;
  logic        w_need_word;
  logic        w_msb;

  sclk_edge_det u_sclk_edge_det (
    .i_pclk (pclk),
    .i_rst  (rst),
    .i_sclk (sclk),
    .o_fall (w_fall)
  );

  assign w_msb = r_w32 ? r_shift[W32-1] : r_shift[W16-1];

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ws    <= 1'b0;
      r_sd    <= 1'b0;
      r_cnt   <= 5'd0;
      r_shift <= 32'd0;
      r_w32   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ws    <= w_ws_nxt;
      r_sd    <= w_sd_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_w32   <= w_w32_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ws_nxt    = r_ws;
    w_sd_nxt    = r_sd;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_w32_nxt   = r_w32;
    w_fetch     = 1'b0;
    w_need_word = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_fall && (OP.mode == MT)) begin
          w_state_nxt = SHIFT;
          w_fetch     = 1'b1;
          w_need_word = 1'b1;
          w_ws_nxt    = 1'b0;
          w_sd_nxt    = 1'b0;
        end
      end
      SHIFT: begin
        if (OP.mode != MT) begin
          w_state_nxt = IDLE;
          w_ws_nxt    = 1'b0;
          w_sd_nxt    = 1'b0;
          w_cnt_nxt   = 5'd0;
          w_shift_nxt = 32'd0;
        end else if (w_fall) begin
          w_sd_nxt = w_msb;
          if (r_cnt == 5'd0) begin
            // LSB goes out while ws flips, so ws leads the next MSB by one sclk.
            w_fetch     = 1'b1;
            w_ws_nxt    = ~r_ws;
            w_need_word = OP.stereo | r_ws;
          end else begin
            w_shift_nxt = r_shift << 1;
            w_cnt_nxt   = r_cnt - 5'd1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Slot geometry and mono/stereo are sampled only here, at the slot boundary.
    if (w_fetch) begin
      w_w32_nxt = (OP.frame_size == f32bits);
      w_cnt_nxt = last_bit(OP.frame_size);
      if (w_need_word && tx_valid) begin
        w_shift_nxt = w_w32_nxt ? tx_data : {16'h0000, tx_data[15:0]};
      end else begin
        w_shift_nxt = 32'd0;
      end
    end
  end

  assign tx_ready = w_fetch & w_need_word;
  assign underrun = w_fetch & w_need_word & ~tx_valid;
  assign ws       = r_ws;
  assign sd       = r_sd;
  assign busy     = (r_state != IDLE);

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [7:0] r_underrun_cnt;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_underrun_cnt <= 8'd0;
    end else if (underrun && (r_underrun_cnt != 8'hFF)) begin
      r_underrun_cnt <= r_underrun_cnt + 8'd1;
    end
  end

  assign underrun_cnt = r_underrun_cnt;
`endif

endmodule

// File: doc/i2s_tx_serializer.md
I2S_TX_SERIALIZER -- requirements
Module: i2s_tx_serializer

Interface
REQ-001 SHALL have port pclk, input, 1, system clock; all logic on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port sclk, input, 1, bit clock from clk_div (sclk output), sampled as data on pclk.
REQ-004 SHALL have port OP, input, OP_t (ctrl_pkg), uses fields mode, stereo, frame_size.
REQ-005 SHALL have port tx_data, input, 32, next channel word, LSB-aligned (16-bit frame uses [15:0]).
REQ-006 SHALL have port tx_valid, input, 1, tx_data available from upstream FIFO.
REQ-007 SHALL have port tx_ready, output, 1, single-pclk pop strobe; word consumed when tx_valid && tx_ready.
REQ-008 SHALL have port ws, output, 1, word select (0 = left, 1 = right).
REQ-009 SHALL have port sd, output, 1, serial data, MSB first.
REQ-010 SHALL have port underrun, output, 1, single-pclk pulse when a word fetch finds tx_valid low.
REQ-011 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-012 SHALL pass sclk through a 2-flop synchronizer and generate a one-pclk fall event on the synchronized 1->0 transition.
REQ-013 SHALL update ws and sd only in the pclk cycle of a fall event; latency from sclk falling edge to sd/ws change is 3 pclk.
REQ-014 SHALL require pclk >= 4x sclk; behaviour below that ratio is undefined.
REQ-015 SHALL implement states IDLE, SHIFT (tx_state_t).
REQ-016 IDLE: ws=0, sd=0, tx_ready=0; on a fall event with OP.mode==MT -> SHIFT; that event is a fetch event (REQ-018) with ws driven 0 and sd driven 0.
REQ-017 SHIFT: each fall event drives sd = shift-register MSB, shifts left, and decrements the bit counter from W-1 to 0, where W = 16 (f16bits) or 32 (f32bits).
REQ-018 Fetch event: the fall event that drives bit 0 (LSB) of a slot; SHALL toggle ws and assert tx_ready for that pclk cycle only.
REQ-019 At a fetch event with tx_valid=1, SHALL load tx_data[W-1:0] into the shift register (MSB at bit W-1) and reload the counter to W-1.
REQ-020 At a fetch event with tx_valid=0, SHALL load zeros and pulse underrun; the ws cadence is unaffected.
REQ-021 Result: ws changes one sclk before the MSB of each slot (I2S standard).
REQ-022 Mono (OP.stereo=0): left slot fetches a word; the right slot shall transmit W zeros without tx_ready and without underrun.
REQ-023 OP.mode != MT while in SHIFT: return to IDLE on the next pclk, sd=0, ws=0, and discard the shift register.
REQ-024 OP.frame_size and OP.stereo changes take effect only at the next fetch event.
REQ-025 A fall event coincident with rst SHALL be ignored.

Reset
REQ-026 rst SHALL asynchronously force state=IDLE, ws=0, sd=0, tx_ready=0, underrun=0, busy=0, synchronizer flops=0, counter=0, shift register=0.
REQ-027 Reset mid-frame SHALL drop the partial word without popping a further word.

Configuration
REQ-028 With I2S_TX_UNDERRUN_CNT_EN defined, SHALL add output underrun_cnt[7:0], a saturating count of underrun pulses (holds at 255), cleared by rst.
REQ-029 Without I2S_TX_UNDERRUN_CNT_EN, port underrun_cnt and its counter SHALL not exist; all other behaviour is identical.

Structure
REQ-030 ctrl_pkg SHALL hold tx_state_t and constants W16=16 and W32=32; OP_t is reused unchanged.
REQ-031 SHALL instantiate one sub-module, sclk_edge_det (synchronizer plus fall-event generator).

Verification
REQ-032 Bench: stereo, f16bits, words 0xA5A5 then 0x3C3C -> sd=1010010110100101 with ws=0, then 0011110000111100 with ws=1; ws toggles on the LSB bit.
REQ-033 Bench: stereo, f32bits, tx_valid=0 for the right slot -> 32 zero bits on sd, exactly one underrun pulse, ws cadence intact; with the macro defined, underrun_cnt=1.
REQ-034 Bench: mono, f16bits, word 0xFFFF -> 16 ones at ws=0, 16 zeros at ws=1, one tx_ready per 32 sclk.
REQ-035 Bench: rst asserted mid-slot at bit 7 -> ws=0, sd=0, busy=0 immediately; after release, the first fall event restarts from IDLE.
REQ-036 Bench: OP.mode switched to MR mid-frame -> IDLE on the next pclk, no further tx_ready.
REQ-037 Bench: 300 consecutive underruns with the macro defined -> underrun_cnt saturates at 255.
